time_digit_scanner: RTL and testbench
=====================================

Name: time_digit_scanner

Overview:
Downstream display stage of the clock core. It captures a binary hour/minute/second snapshot on a load pulse and converts each field to two BCD digits with a sequential subtract-by-10 FSM. It time-multiplexes the six digits onto one 7-segment bus with one-hot digit enables, and presents a colon blink signal derived from the captured seconds.

Parameters:
SCAN_DIV_W, 10, prescaler width; each digit is shown for 2^SCAN_DIV_W clock cycles.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  one-cycle request to capture hour/minute/second
hour  input  5  binary hours (0..31 accepted)
minute  input  6  binary minutes (0..63 accepted)
second  input  6  binary seconds (0..63 accepted)
busy  output  1  high while a conversion is in progress
segment  output  7  segment drive, bit0=a .. bit6=g, active high, registered
digit_en  output  6  one-hot digit select; bit0 = hour tens (leftmost), bit5 = second ones; registered
colon  output  1  1 when the captured second is even; registered

Behaviour:
- Reset (async, any time, including mid-conversion):
  - FSM to IDLE; busy=0; segment=0; digit_en=0; colon=0.
  - Display register (6 BCD digits) cleared to 0; prescaler=0; digit index=0.
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, COMMIT.
- IDLE:
  - load=1 captures hour, minute and second into working registers, clears the tens accumulator, moves to CONV_H and sets busy=1 on the next edge.
  - load while not IDLE is ignored; no queueing.
- CONV_x, each cycle:
  - If rem >= 10: rem <= rem-10 and tens <= tens+1.
  - Else: store {tens, rem} into the working digits for that field, clear tens, advance CONV_H->CONV_M->CONV_S->COMMIT.
  - Cycles per field = floor(value/10)+1.
- COMMIT, one cycle:
  - All six working digits are copied into the display register atomically.
  - colon source updated from the captured second bit0 (colon=1 when even).
  - Return to IDLE with busy=0.
- Latency from the load edge to the display update = (h/10+1)+(m/10+1)+(s/10+1)+1 cycles. Examples: 23:59:59 -> 16; 00:00:00 -> 4.
- Out-of-range inputs are converted literally: 63 -> "63", 31 -> "31". Tens digits reach at most 6 and never exceed 9.
- Scan:
  - Prescaler free-runs from reset.
  - When it wraps from all-ones to 0, the digit index advances 0,1,2,3,4,5,0...
- Output registers update every cycle:
  - digit_en = one-hot(index).
  - segment = decode(display[index]).
  - The first visible value appears one cycle after reset release: digit_en=000001, segment=3F.
- Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes 10..15 give 00.
- Display changes take effect at the COMMIT edge; the next segment register update shows the new digit. The scan phase is undisturbed by load and conversion.

Optional Feature:
- Macro: LEADING_BLANK_EN.
- Defined: when index=0 and display hour tens = 0, segment=00 (blank); all other digits are unaffected.
- Undefined: the hour tens digit shows 3F for zero like every other digit.

Test Plan:
- Reset asserted, then released -> busy=0, digit_en=0, segment=0 during reset; one cycle after release digit_en=000001, segment=3F.
- Load 23:59:59 -> busy high exactly 16 cycles; afterwards the scan shows 5B, 4F, 6D, 6F, 6D, 6F on digits 0..5; colon=0.
- SCAN_DIV_W=2, free run -> digit_en steps 000001->000010->...->100000->000001, 4 cycles per step.
- Load 12:34:56, then load 00:00:00 three cycles later -> second load ignored; busy lasts 13 cycles; display 1,2,3,4,5,6; colon=1.
- Load 23:59:59, reset pulse at cycle 5 of the conversion -> busy=0, all digits 3F; a subsequent load of 01:02:03 completes in 4 cycles and shows 0,1,0,2,0,3.
- Load 07:05:00 -> digit 0 segment = 00 with LEADING_BLANK_EN, 3F without; digits 1..5 show 07, 3F, 6D, 3F, 3F.

Source files
------------

// File: rtl/time_digit_scanner.sv
// Purpose : captures an h:m:s snapshot, converts it to six BCD digits and scans them onto a 7-segment bus.
// Latency : display updates (h/10+1)+(m/10+1)+(s/10+1)+1 cycles after the load edge; scan outputs are registered.
// Backpres: none; a load that arrives while busy is dropped (no queueing).
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   load, hour/minute/second  one-cycle capture request and binary time fields
//   busy                    high while a conversion is in progress
//   segment                 registered segment drive, bit0=a .. bit6=g, active high
//   digit_en                registered one-hot digit select, bit0 = hour tens
//   colon                   registered, 1 when the captured second is even
// Optional feature macro: LEADING_BLANK_EN blanks a zero hour-tens digit.
module time_digit_scanner #(
    parameter int SCAN_DIV_W = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    output logic       busy,
    output logic [6:0] segment,
    output logic [5:0] digit_en,
    output logic       colon
);

    typedef enum logic [2:0] {IDLE, CONV_H, CONV_M, CONV_S, COMMIT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [5:0]              rem;
    logic [2:0]              tens;        // field values are < 64, so tens never exceeds 6
    logic [5:0]              min_cap;
    logic [5:0]              sec_cap;
    logic [5:0][3:0]         work;
    logic [5:0][3:0]         display;
    logic                    colon_src;
    logic [SCAN_DIV_W-1:0]   prescaler;
    logic [2:0]              idx;
    logic                    field_done;
    logic [2:0]              wbase;
    logic [6:0]              seg_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign field_done = (rem < 6'd10);
    assign busy       = (state != IDLE);

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wbase     = 3'd0;
        case (state)
            IDLE:    if (load) state_nxt = CONV_H;
            CONV_H:  if (field_done) state_nxt = CONV_M;
            CONV_M: begin
                wbase = 3'd2;
                if (field_done) state_nxt = CONV_S;
            end
            CONV_S: begin
                wbase = 3'd4;
                if (field_done) state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: one subtract-by-10 per cycle; when a field finishes,
    // rem is reloaded with the next captured field in the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem       <= '0;
            tens      <= '0;
            min_cap   <= '0;
            sec_cap   <= '0;
            work      <= '0;
            display   <= '0;
            colon_src <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        rem     <= {1'b0, hour};
                        min_cap <= minute;
                        sec_cap <= second;
                        tens    <= '0;
                    end
                end
                CONV_H, CONV_M, CONV_S: begin
                    if (!field_done) begin
                        rem  <= rem - 6'd10;
                        tens <= tens + 3'd1;
                    end else begin
                        work[wbase]        <= {1'b0, tens};
                        work[wbase + 3'd1] <= rem[3:0];
                        tens               <= '0;
                        rem                <= (state == CONV_H) ? min_cap : sec_cap;
                    end
                end
                COMMIT: begin
                    display   <= work;
                    colon_src <= ~sec_cap[0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- display scan ----------------
    always_comb begin
        seg_nxt = seg_decode(display[idx]);
`ifdef LEADING_BLANK_EN
        if (idx == 3'd0 && display[0] == 4'd0) seg_nxt = 7'h00;
`endif
    end

    // Prescaler and digit index free-run from reset; loads never disturb the scan phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
            segment   <= '0;
            digit_en  <= '0;
            colon     <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            segment   <= seg_nxt;
            digit_en  <= 6'd1 << idx;
            colon     <= colon_src;
        end
    end

endmodule

// File: tb/tb_time_digit_scanner.sv
// Purpose : randomized scoreboard bench for time_digit_scanner.
// Latency : expected display/colon/busy-length pushed at load, popped when busy falls.
// Backpres: scan outputs compared every cycle against an arithmetic time-based model.
module tb_time_digit_scanner;

    localparam int SCAN_DIV_W = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic [4:0] hour   = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       busy;
    logic [6:0] segment;
    logic [5:0] digit_en;
    logic       colon;

    time_digit_scanner #(.SCAN_DIV_W(SCAN_DIV_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .busy     (busy),
        .segment  (segment),
        .digit_en (digit_en),
        .colon    (colon)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0][3:0] d;
        logic            col;
        int              len;
    } exp_t;

    exp_t            q[$];
    logic [5:0][3:0] model_disp = '0;
    logic            model_col  = 1'b0;
    int              cnt   = 0;
    int              blen  = 0;
    int              total = 0;
    int              passes = 0;
    logic [6:0]      seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [6:0] exp_seg(input int i, input logic [3:0] d);
`ifdef LEADING_BLANK_EN
        if (i == 0 && d == 4'd0) return 7'h00;
`endif
        return seg_tbl[d];
    endfunction

    function automatic exp_t make_exp(input int h, input int m, input int s);
        exp_t e;
        e.d[0] = 4'(h / 10); e.d[1] = 4'(h % 10);
        e.d[2] = 4'(m / 10); e.d[3] = 4'(m % 10);
        e.d[4] = 4'(s / 10); e.d[5] = 4'(s % 10);
        e.col  = (s % 2 == 0);
        e.len  = h / 10 + m / 10 + s / 10 + 4;
        return e;
    endfunction

    // Monitor: scan checks every cycle, scoreboard pop when a conversion ends.
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_segment", 32'(segment), 0);
            chk("rst_digit_en", 32'(digit_en), 0);
            chk("rst_colon", 32'(colon), 0);
            q.delete();
            model_disp = '0;
            model_col  = 1'b0;
            cnt  = 0;
            blen = 0;
        end else begin
            int   i;
            exp_t e;
            logic [5:0] one;
            cnt++;
            // Edge k after reset release presents digit floor((k-1)/2^W) mod 6.
            i   = ((cnt - 1) >> SCAN_DIV_W) % 6;
            one = 6'd1;
            chk("scan_digit_en", 32'(digit_en), 32'(one << i));
            chk("scan_segment", 32'(segment), 32'(exp_seg(i, model_disp[i])));
            chk("colon", 32'(colon), 32'(model_col));
            if (busy) blen++;
            else if (blen > 0) begin
                chk("scoreboard_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("busy_cycles", 32'(blen), 32'(e.len));
                    model_disp = e.d;
                    model_col  = e.col;
                end
                blen = 0;
            end
        end
    end

    task automatic do_load(input int h, input int m, input int s, input bit accepted);
        @(posedge clock); #1;
        if (accepted) q.push_back(make_exp(h, m, s));
        hour = 5'(h); minute = 6'(m); second = 6'(s); load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("idle_within_bound", 32'(busy), 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock); #1 reset = 1'b1;
        repeat (cycles) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        repeat (60) @(posedge clock);

        do_load(23, 59, 59, 1); wait_idle(); repeat (30) @(posedge clock);

        do_load(12, 34, 56, 1);
        repeat (2) @(posedge clock);
        do_load(0, 0, 0, 0);
        wait_idle(); repeat (30) @(posedge clock);

        do_load(23, 59, 59, 1);
        repeat (5) @(negedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        repeat (10) @(posedge clock);
        do_load(1, 2, 3, 1); wait_idle(); repeat (30) @(posedge clock);

        do_load(7, 5, 0, 1);  wait_idle(); repeat (30) @(posedge clock);
        do_load(31, 63, 63, 1); wait_idle(); repeat (30) @(posedge clock);

        for (int k = 0; k < 40; k++) begin
            do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)), 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clock);
                do_load(int'($urandom_range(0, 31)), 0, 0, 0);
            end
            wait_idle();
            repeat ($urandom_range(0, 30)) @(posedge clock);
        end

        do_reset(2);
        repeat (30) @(posedge clock);
        do_load(0, 0, 0, 1); wait_idle(); repeat (30) @(posedge clock);

        repeat (2) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
